// File: rtl/vpu_alu_ui_mul_seq_pkg.sv
// Shared types and defaults for the VPU ALU unsigned integer shift-add multiplier.
package vpu_alu_ui_mul_seq_pkg;

  localparam int unsigned OPERAND_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } ui_mul_state_t;

endpackage

// File: rtl/vpu_alu_ui_mul_step.sv
// One shift-add iteration: conditionally add the multiplicand, then shift both operands.
module vpu_alu_ui_mul_step #(
  parameter int unsigned W = 32
) (
  input  logic [2*W-1:0] acc,
  input  logic [2*W-1:0] mcand,
  input  logic [W-1:0]   mplier,
  output logic [2*W-1:0] acc_nxt,
  output logic [2*W-1:0] mcand_nxt,
  output logic [W-1:0]   mplier_nxt,
  output logic           last
);

  // mcand never exceeds op_0 << (W-1), so the 2W-bit sum cannot overflow
  always_comb begin
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
    last       = (mplier_nxt == '0);
  end

endmodule

// File: rtl/vpu_alu_ui_mul_seq.sv
// Multi-cycle unsigned multiplier: one multiplier bit per cycle, early exit when
// the remaining multiplier bits are zero, valid/ready on both sides.
module vpu_alu_ui_mul_seq
  import vpu_alu_ui_mul_seq_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH = vpu_alu_ui_mul_seq_pkg::OPERAND_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [OPERAND_WIDTH-1:0]     op_0,
  input  logic [OPERAND_WIDTH-1:0]     op_1,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [2*OPERAND_WIDTH-1:0]   result_o,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy_o
);

  localparam int unsigned W     = OPERAND_WIDTH;
  localparam int unsigned RW    = 2 * W;
  localparam int unsigned CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  ui_mul_state_t    state_q;
  ui_mul_state_t    state_d;
  logic [RW-1:0]    acc_q;
  logic [RW-1:0]    mcand_q;
  logic [W-1:0]     mplier_q;
  logic [CNT_W-1:0] cnt_q;

  logic [RW-1:0]    acc_nxt;
  logic [RW-1:0]    mcand_nxt;
  logic [W-1:0]     mplier_nxt;
  logic             step_last;
  logic             accept;
  logic             finish;
  logic             drain;

  vpu_alu_ui_mul_step #(
    .W (W)
  ) u_step (
    .acc        (acc_q),
    .mcand      (mcand_q),
    .mplier     (mplier_q),
    .acc_nxt    (acc_nxt),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt),
    .last       (step_last)
  );

  assign accept = in_valid && in_ready;
  assign finish = (cnt_q == CNT_LAST) || step_last;
  assign drain  = (state_q == MUL_DONE) && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a drain and a new accept in the same cycle go straight back to BUSY
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MUL_IDLE: begin
        if (accept) state_d = MUL_BUSY;
      end
      MUL_BUSY: begin
        if (!en) begin
          state_d = MUL_IDLE;
        end else if (finish) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (out_ready) state_d = accept ? MUL_BUSY : MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    in_ready = 1'b0;
    busy_o   = 1'b0;
    in_ready = !rst && en && ((state_q == MUL_IDLE) || drain);
    busy_o   = (state_q != MUL_IDLE);
  end

  // Operand, counter and result registers; an abort simply leaves them untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      result_o  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        acc_q    <= '0;
        mcand_q  <= {{W{1'b0}}, op_0};
        mplier_q <= op_1;
        cnt_q    <= '0;
      end else if ((state_q == MUL_BUSY) && en) begin
        acc_q    <= acc_nxt;
        mcand_q  <= mcand_nxt;
        mplier_q <= mplier_nxt;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (finish) begin
          result_o  <= acc_nxt;
          out_valid <= 1'b1;
        end
      end
      if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vpu_alu_ui_mul_seq.sv
// Directed and randomized checks of the shift-add multiplier against a product/latency model.
module tb_vpu_alu_ui_mul_seq;

  localparam int unsigned W     = 8;
  localparam int          N_OPS = 3000;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [W-1:0]    op_0;
  logic [W-1:0]    op_1;
  logic            in_valid;
  logic            in_ready;
  logic [2*W-1:0]  result_o;
  logic            out_valid;
  logic            out_ready;
  logic            busy_o;

  int checks   = 0;
  int failures = 0;

  vpu_alu_ui_mul_seq #(
    .OPERAND_WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .op_0      (op_0),
    .op_1      (op_1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result_o  (result_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Busy cycles: position of the highest set multiplier bit, at least one
  function automatic int busy_len(input logic [W-1:0] b);
    int n = 1;
    for (int i = 0; i < int'(W); i++) begin
      if (b[i]) n = i + 1;
    end
    return n;
  endfunction

  function automatic logic [2*W-1:0] product(input logic [W-1:0] a, input logic [W-1:0] b);
    return (2*W)'(a) * (2*W)'(b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    op_0 = a;
    op_1 = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("accept_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    op_0 = W'($urandom);
    op_1 = W'($urandom);
  endtask

  task automatic wait_done(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_cycles"}, 64'(n), 64'(busy_len(b)));
    check({tag, "_result"}, 64'(result_o), 64'(product(a, b)));
    check({tag, "_busy"}, 64'(busy_o), 64'(1));
  endtask

  logic [2*W-1:0] exp_q[$];
  int             due_q[$];

  initial begin
    int  tick_no   = 0;
    int  accepted  = 0;
    int  delivered = 0;
    int  aborted   = 0;
    int  ov_seen   = 0;
    bit  reported  = 1'b0;
    bit  hs_in, hs_out, abort_now;
    logic [W-1:0] ra, rb;

    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_0 = '0; op_1 = '0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("rst_result", 64'(result_o), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("idle_in_ready", 64'(in_ready), 64'(1));

    // Basic products with an always-ready sink
    out_ready = 1'b1;
    start_op(8'd13, 8'd11);
    wait_done("m13x11", 8'd13, 8'd11);
    tick();
    check("m13x11_ov_pulse", 64'(out_valid), 64'(0));
    check("m13x11_idle", 64'(busy_o), 64'(0));
    start_op(8'd255, 8'd255);
    wait_done("m255x255", 8'd255, 8'd255);
    tick();
    start_op(8'd200, 8'd0);
    wait_done("m200x0", 8'd200, 8'd0);
    tick();

    // Back-pressure then zero-bubble accept on the draining cycle
    out_ready = 1'b0;
    start_op(8'd6, 8'd7);
    wait_done("m6x7", 8'd6, 8'd7);
    op_0 = 8'd3; op_1 = 8'd3; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_result", 64'(result_o), 64'(42));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("zb_in_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    check("zb_ov_drop", 64'(out_valid), 64'(0));
    check("zb_busy", 64'(busy_o), 64'(1));
    wait_done("m3x3", 8'd3, 8'd3);
    tick();

    // Abort via en=0 in the second BUSY cycle
    start_op(8'd100, 8'd200);
    tick();
    en = 1'b0;
    tick();
    check("abort_busy", 64'(busy_o), 64'(0));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_result_kept", 64'(result_o), 64'(9));
    check("abort_in_ready_en0", 64'(in_ready), 64'(0));
    en = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 10; i++) begin
      if (out_valid) ov_seen++;
      tick();
    end
    check("abort_no_out_valid", 64'(ov_seen), 64'(0));

    // Reset in the third BUSY cycle
    start_op(8'd170, 8'd85);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_result", 64'(result_o), 64'(0));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy_o), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    #1;
    start_op(8'd2, 8'd3);
    wait_done("m2x3", 8'd2, 8'd3);
    tick();

    // Random traffic: every accepted op is delivered once or aborted, never duplicated
    for (int cyc = 0; cyc < 60000; cyc++) begin
      if (accepted >= N_OPS && exp_q.size() == 0) break;
      tick();
      tick_no++;
      if (out_valid && !reported) begin
        reported = 1'b1;
        check("rnd_pending", 64'(exp_q.size()), 64'(1));
        if (exp_q.size() != 0) begin
          check("rnd_result", 64'(result_o), 64'(exp_q[0]));
          check("rnd_latency", 64'(tick_no), 64'(due_q[0]));
        end
      end
      en        = ($urandom_range(0, 31) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (accepted < N_OPS) && ($urandom_range(0, 2) != 0);
      ra = W'($urandom >> $urandom_range(0, 7));
      rb = W'($urandom >> $urandom_range(0, 7));
      op_0 = ra;
      op_1 = rb;
      #1;
      hs_out    = out_valid && out_ready;
      hs_in     = in_valid && in_ready;
      abort_now = !en && (exp_q.size() != 0) && !out_valid;
      if ((hs_out || abort_now) && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        if (hs_out) delivered++;
        else aborted++;
      end
      if (hs_out) reported = 1'b0;
      if (hs_in) begin
        exp_q.push_back(product(ra, rb));
        due_q.push_back(tick_no + 1 + busy_len(rb));
        accepted++;
      end
    end
    check("rnd_accepted", 64'(accepted), 64'(N_OPS));
    check("rnd_conserved", 64'(delivered + aborted), 64'(accepted));
    check("rnd_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
